// File: rtl/time_report_pkg.sv
// -----------------------------------------------------------------------------
// time_report_pkg
// Shared declarations for the time-report transmitter: FSM state encoding,
// ASCII constants, report lengths and the decimal saturation helper.
// -----------------------------------------------------------------------------
package time_report_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_e;

    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] LF   = 8'h0A;
    localparam logic [7:0] DOT  = 8'h2E;
    localparam logic [7:0] ZERO = 8'h30;

    // "HH:MM:SS\r\n" and "HH:MM:SS.CC\r\n"
    localparam logic [3:0] LEN_HMS  = 4'd10;
    localparam logic [3:0] LEN_HMSC = 4'd13;

    // Clamp a field to the largest two-digit decimal value.
    function automatic logic [6:0] sat99(input logic [6:0] v);
        if (v > 7'd99) begin
            return 7'd99;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/time_report_if.sv
// -----------------------------------------------------------------------------
// time_report_if
// Byte-push link between the time-report transmitter and the UART TX FIFO.
//   tx_full : FIFO full flag (FIFO -> transmitter)
//   tx_push : one-cycle push strobe per byte (transmitter -> FIFO)
//   tx_data : ASCII byte, valid while tx_push is high (transmitter -> FIFO)
// -----------------------------------------------------------------------------
interface time_report_if;
    logic       tx_full;
    logic       tx_push;
    logic [7:0] tx_data;

    modport master (input tx_full, output tx_push, output tx_data);
    modport slave  (output tx_full, input tx_push, input tx_data);
endinterface

// File: rtl/bin2ascii2.sv
// -----------------------------------------------------------------------------
// bin2ascii2
// Combinational converter: 7-bit binary value to two zero-padded ASCII
// decimal digits. Values of 100 and above are shown as "99".
//   bin_i  : binary field value
//   tens_o : ASCII tens digit
//   ones_o : ASCII ones digit
// -----------------------------------------------------------------------------
module bin2ascii2
    import time_report_pkg::*;
(
    input  logic [6:0] bin_i,
    output logic [7:0] tens_o,
    output logic [7:0] ones_o
);

    logic [6:0] sat_s;

    // Saturate, then split into decimal digits offset by ASCII '0'.
    always_comb begin
        sat_s  = sat99(bin_i);
        tens_o = ZERO + 8'(sat_s / 7'd10);
        ones_o = ZERO + 8'(sat_s % 7'd10);
    end

endmodule

// File: rtl/time_report_tx.sv
// -----------------------------------------------------------------------------
// time_report_tx
// On a single-cycle request, snapshots the watch time and pushes it into the
// UART TX FIFO as "HH:MM:SS\r\n" (or "HH:MM:SS.CC\r\n" when the macro
// TIME_REPORT_CENTI_EN is defined), honouring the FIFO full flag and an
// optional inter-byte idle gap.
// Parameters:
//   SEP_CHAR : separator byte between HH/MM and MM/SS
//   CHAR_GAP : idle cycles inserted after every push except the last
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset
//   req    : report request (ignored unless idle)
//   i_hour, i_min, i_sec, i_cent : live time fields (binary)
//   tx     : FIFO push link (master side)
//   busy   : report in progress
//   done   : one-cycle pulse after the final byte
// -----------------------------------------------------------------------------
module time_report_tx
    import time_report_pkg::*;
#(
    parameter logic [7:0] SEP_CHAR = 8'h3A,
    parameter int         CHAR_GAP = 0
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [4:0]    i_hour,
    input  logic [5:0]    i_min,
    input  logic [5:0]    i_sec,
    input  logic [6:0]    i_cent,
    time_report_if.master tx,
    output logic          busy,
    output logic          done
);

`ifdef TIME_REPORT_CENTI_EN
    localparam logic [3:0] REPORT_LEN = LEN_HMSC;
`else
    localparam logic [3:0] REPORT_LEN = LEN_HMS;
`endif
    localparam logic [3:0] LAST_IDX = REPORT_LEN - 4'd1;

    // Gap counter sized for CHAR_GAP-1 with a one-bit floor.
    localparam int             GW         = (CHAR_GAP > 1) ? $clog2(CHAR_GAP) : 1;
    localparam int             GAP_LOAD_I = (CHAR_GAP > 0) ? (CHAR_GAP - 1) : 0;
    localparam logic [GW-1:0]  GAP_LOAD   = GW'(GAP_LOAD_I);

    state_e        state_q;
    logic [3:0]    idx_q;
    logic [GW-1:0] gap_q;
    logic          busy_q;
    logic          done_q;
    logic [4:0]    hour_q;
    logic [5:0]    min_q;
    logic [5:0]    sec_q;
`ifdef TIME_REPORT_CENTI_EN
    logic [6:0]    cent_q;
`else
    logic          unused_cent_s;
    assign unused_cent_s = ^i_cent;
`endif

    logic       push_s;
    logic [6:0] field_s;
    logic [7:0] tens_s;
    logic [7:0] ones_s;
    logic [7:0] byte_s;
    logic [7:0] data_s;

    // Push is combinational on tx_full so a full FIFO stalls in the same cycle.
    always_comb begin
        push_s = 1'b0;
        if (state_q == SEND) begin
            push_s = ~tx.tx_full;
        end else begin
            push_s = 1'b0;
        end
    end

    // Select the snapshot field whose digit is emitted at the current index.
    always_comb begin
        field_s = 7'd0;
        case (idx_q)
            4'd0, 4'd1: field_s = 7'(hour_q);
            4'd3, 4'd4: field_s = 7'(min_q);
            4'd6, 4'd7: field_s = 7'(sec_q);
`ifdef TIME_REPORT_CENTI_EN
            4'd9, 4'd10: field_s = cent_q;
`endif
            default: field_s = 7'd0;
        endcase
    end

    bin2ascii2 u_bin2ascii2 (
        .bin_i  (field_s),
        .tens_o (tens_s),
        .ones_o (ones_s)
    );

    // Map the byte index onto the report layout.
    always_comb begin
        byte_s = 8'h00;
`ifdef TIME_REPORT_CENTI_EN
        case (idx_q)
            4'd0, 4'd3, 4'd6, 4'd9:  byte_s = tens_s;
            4'd1, 4'd4, 4'd7, 4'd10: byte_s = ones_s;
            4'd2, 4'd5:              byte_s = SEP_CHAR;
            4'd8:                    byte_s = DOT;
            4'd11:                   byte_s = CR;
            4'd12:                   byte_s = LF;
            default:                 byte_s = 8'h00;
        endcase
`else
        case (idx_q)
            4'd0, 4'd3, 4'd6: byte_s = tens_s;
            4'd1, 4'd4, 4'd7: byte_s = ones_s;
            4'd2, 4'd5:       byte_s = SEP_CHAR;
            4'd8:             byte_s = CR;
            4'd9:             byte_s = LF;
            default:          byte_s = 8'h00;
        endcase
`endif
    end

    // Data is forced to zero outside SEND so the bus is quiet when idle.
    always_comb begin
        data_s = 8'h00;
        if (state_q == SEND) begin
            data_s = byte_s;
        end else begin
            data_s = 8'h00;
        end
    end

    assign tx.tx_push = push_s;
    assign tx.tx_data = data_s;
    assign busy       = busy_q;
    assign done       = done_q;

    // Report FSM: snapshot, byte sequencing, gap timing and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            gap_q   <= {GW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hour_q  <= 5'd0;
            min_q   <= 6'd0;
            sec_q   <= 6'd0;
`ifdef TIME_REPORT_CENTI_EN
            cent_q  <= 7'd0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        hour_q  <= i_hour;
                        min_q   <= i_min;
                        sec_q   <= i_sec;
`ifdef TIME_REPORT_CENTI_EN
                        cent_q  <= i_cent;
`endif
                        idx_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= SEND;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SEND: begin
                    if (push_s) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= 4'd0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                            if (CHAR_GAP > 0) begin
                                gap_q   <= GAP_LOAD;
                                state_q <= GAP;
                            end else begin
                                state_q <= SEND;
                            end
                        end
                    end else begin
                        state_q <= SEND;
                    end
                end
                GAP: begin
                    if (gap_q == {GW{1'b0}}) begin
                        state_q <= SEND;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_report_tx.sv
// -----------------------------------------------------------------------------
// tb_time_report_tx
// Directed bench for time_report_tx. dut0 runs with no inter-byte gap, dut1
// with a two-cycle gap. Expected bytes are queued when a request is issued and
// popped by per-DUT monitors on every push.
// -----------------------------------------------------------------------------
module tb_time_report_tx;

`ifdef TIME_REPORT_CENTI_EN
    localparam int LEN = 13;
`else
    localparam int LEN = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req0;
    logic       req1;
    logic [4:0] hour;
    logic [5:0] mins;
    logic [5:0] secs;
    logic [6:0] cent;
    logic       busy0, done0, busy1, done1;

    time_report_if tx0 ();
    time_report_if tx1 ();

    time_report_tx #(.SEP_CHAR(8'h3A), .CHAR_GAP(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .i_hour(hour), .i_min(mins),
        .i_sec(secs), .i_cent(cent), .tx(tx0), .busy(busy0), .done(done0)
    );

    time_report_tx #(.SEP_CHAR(8'h3A), .CHAR_GAP(2)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .i_hour(hour), .i_min(mins),
        .i_sec(secs), .i_cent(cent), .tx(tx1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    int push0 [$];
    int push1 [$];
    int done0_cyc [$];
    int done1_cyc [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] dig(input int v, input bit tens);
        int s;
        s = (v >= 100) ? 99 : v;
        if (tens) return 8'(48 + s / 10);
        else      return 8'(48 + s % 10);
    endfunction

    task automatic expect_report(input int which, input int h, input int m, input int s, input int c);
        logic [7:0] b [$];
        b = '{dig(h, 1'b1), dig(h, 1'b0), 8'h3A, dig(m, 1'b1), dig(m, 1'b0), 8'h3A,
              dig(s, 1'b1), dig(s, 1'b0), 8'h2E, dig(c, 1'b1), dig(c, 1'b0), 8'h0D, 8'h0A};
        if (LEN == 10) begin
            b.delete(8);
            b.delete(8);
            b.delete(8);
        end
        foreach (b[i]) begin
            if (which == 0) exp0.push_back(b[i]);
            else            exp1.push_back(b[i]);
        end
    endtask

    // Scoreboard monitor for dut0, sampled on the falling edge.
    always @(negedge clk) begin
        if (tx0.tx_push === 1'b1) begin
            push0.push_back(cyc);
            n_vec++;
            assert (exp0.size() > 0) else begin
                n_err++;
                $error("FAIL dut0_spurious_push: observed byte 0x%0h expected no push", tx0.tx_data);
            end
            if (exp0.size() > 0) check("dut0_byte", 32'(tx0.tx_data), 32'(exp0.pop_front()));
        end
        if (done0 === 1'b1) begin
            done0_cyc.push_back(cyc);
            check("dut0_busy_in_fin", 32'(busy0), 32'd0);
        end
    end

    // Scoreboard monitor for dut1, sampled on the falling edge.
    always @(negedge clk) begin
        if (tx1.tx_push === 1'b1) begin
            push1.push_back(cyc);
            n_vec++;
            assert (exp1.size() > 0) else begin
                n_err++;
                $error("FAIL dut1_spurious_push: observed byte 0x%0h expected no push", tx1.tx_data);
            end
            if (exp1.size() > 0) check("dut1_byte", 32'(tx1.tx_data), 32'(exp1.pop_front()));
        end
        if (done1 === 1'b1) begin
            done1_cyc.push_back(cyc);
            check("dut1_busy_in_fin", 32'(busy1), 32'd0);
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input int which);
        if (which == 0) req0 = 1'b1;
        else            req1 = 1'b1;
        step(1);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget, input string tag);
        int n0;
        int got;
        n0  = (which == 0) ? done0_cyc.size() : done1_cyc.size();
        got = 0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            got = (which == 0) ? done0_cyc.size() : done1_cyc.size();
            if (got > n0) break;
        end
        check(tag, 32'(got > n0), 32'd1);
    endtask

    task automatic clear0();
        exp0.delete();
        push0.delete();
        done0_cyc.delete();
    endtask

    initial begin
        int r;
        int f;
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        tx0.tx_full = 1'b0;
        tx1.tx_full = 1'b0;
        hour = 5'd0;
        mins = 6'd0;
        secs = 6'd0;
        cent = 7'd0;
        #2 rst = 1'b0;
        step(2);
        check("rst_push0", 32'(tx0.tx_push), 32'd0);
        check("rst_data0", 32'(tx0.tx_data), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_done0", 32'(done0), 32'd0);
        check("rst_push1", 32'(tx1.tx_push), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        rst = 1'b1;

        // Basic report 13:05:09 requested in cycle 10.
        hour = 5'd13; mins = 6'd5; secs = 6'd9; cent = 7'd42;
        while (cyc < 10) step(1);
        clear0();
        expect_report(0, 13, 5, 9, 42);
        check("t1_busy_before", 32'(busy0), 32'd0);
        start(0);
        check("t1_busy_after", 32'(busy0), 32'd1);
        wait_done(0, 40, "t1_done_timeout");
        check("t1_push_count", 32'(push0.size()), 32'(LEN));
        foreach (push0[k]) check("t1_push_cycle", 32'(push0[k]), 32'(11 + k));
        if (done0_cyc.size() > 0) check("t1_done_cycle", 32'(done0_cyc[0]), 32'(11 + LEN));
        check("t1_sb_empty", 32'(exp0.size()), 32'd0);

        // FIFO full for 5 cycles after the third byte.
        clear0();
        r = cyc;
        expect_report(0, 13, 5, 9, 42);
        start(0);
        step(3);
        tx0.tx_full = 1'b1;
        step(5);
        tx0.tx_full = 1'b0;
        wait_done(0, 40, "t2_done_timeout");
        check("t2_push_count", 32'(push0.size()), 32'(LEN));
        if (push0.size() > 3) check("t2_fourth_cycle", 32'(push0[3]), 32'(r + 9));
        if (push0.size() > 2) check("t2_third_cycle", 32'(push0[2]), 32'(r + 3));
        if (done0_cyc.size() > 0) check("t2_done_cycle", 32'(done0_cyc[0]), 32'(r + 6 + LEN));
        check("t2_sb_empty", 32'(exp0.size()), 32'd0);

        // Second request and input change while busy.
        clear0();
        expect_report(0, 13, 5, 9, 42);
        start(0);
        step(2);
        req0 = 1'b1;
        hour = 5'd23; mins = 6'd59; secs = 6'd59; cent = 7'd99;
        step(1);
        req0 = 1'b0;
        wait_done(0, 40, "t3_done_timeout");
        step(20);
        check("t3_push_count", 32'(push0.size()), 32'(LEN));
        check("t3_done_count", 32'(done0_cyc.size()), 32'd1);
        check("t3_sb_empty", 32'(exp0.size()), 32'd0);

        // Out-of-range minute and centisecond, then back-to-back request.
        clear0();
        hour = 5'd0; mins = 6'd63; secs = 6'd7; cent = 7'd120;
        expect_report(0, 0, 63, 7, 120);
        start(0);
        wait_done(0, 40, "t4_done_timeout");
        f = (done0_cyc.size() > 0) ? done0_cyc[0] : 0;
        hour = 5'd2; mins = 6'd30; secs = 6'd45; cent = 7'd5;
        r = cyc;
        check("t4_req_after_fin", 32'(r), 32'(f + 1));
        expect_report(0, 2, 30, 45, 5);
        start(0);
        wait_done(0, 40, "t4b_done_timeout");
        check("t4_push_count", 32'(push0.size()), 32'(2 * LEN));
        if (push0.size() > LEN) check("t4b_first_push", 32'(push0[LEN]), 32'(r + 1));
        check("t4_sb_empty", 32'(exp0.size()), 32'd0);

        // Reset after the fourth push abandons the report.
        clear0();
        hour = 5'd13; mins = 6'd5; secs = 6'd9; cent = 7'd0;
        expect_report(0, 13, 5, 9, 0);
        start(0);
        step(4);
        rst = 1'b0;
        #1;
        check("t5_push", 32'(tx0.tx_push), 32'd0);
        check("t5_data", 32'(tx0.tx_data), 32'd0);
        check("t5_busy", 32'(busy0), 32'd0);
        check("t5_done", 32'(done0), 32'd0);
        check("t5_pushes_before", 32'(push0.size()), 32'd4);
        exp0.delete();
        step(2);
        rst = 1'b1;
        step(50);
        check("t5_no_push_after", 32'(push0.size()), 32'd4);
        check("t5_busy_after", 32'(busy0), 32'd0);

        // Two idle cycles between pushes on dut1.
        hour = 5'd13; mins = 6'd5; secs = 6'd9; cent = 7'd77;
        r = cyc;
        expect_report(1, 13, 5, 9, 77);
        start(1);
        wait_done(1, 80, "t6_done_timeout");
        check("t6_push_count", 32'(push1.size()), 32'(LEN));
        if (push1.size() > 0) check("t6_first_push", 32'(push1[0]), 32'(r + 1));
        for (int k = 1; k < push1.size(); k++) check("t6_spacing", 32'(push1[k] - push1[k-1]), 32'd3);
        if (push1.size() > 0 && done1_cyc.size() > 0)
            check("t6_done_cycle", 32'(done1_cyc[0]), 32'(push1[push1.size()-1] + 1));
        check("t6_sb_empty", 32'(exp1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
